// File: rtl/tf_seed_loader.sv
// rtl/tf_seed_loader.sv - Framed seed-set loader for the twiddle-factor generator.
// Streams one frame into a shadow bank while the active bank is presented in parallel.
module tf_seed_loader #(
  parameter int DW     = 64,
  parameter int NBASE  = 15,
  parameter int NCONST = 14,
  parameter int DEPTH  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       seed_valid,
  input  logic                       seed_ack,
  output logic [NBASE*DW-1:0]        base_flat,
  output logic [NCONST*DW-1:0]       const_flat,
  output logic [DW-1:0]              modulus_out,
  output logic [$clog2(DEPTH)-1:0]   depth_out,
  output logic                       frame_err
);

  localparam int F   = 1 + NCONST + NBASE;
  localparam int WW  = $clog2(F);
  localparam int DCW = $clog2(DEPTH);

  typedef enum logic {FILL, FULL} state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   widx, widx_nxt;
  logic [DCW-1:0]  dcnt;
  logic [DW-1:0]   shadow [F];
  logic            hs;
  logic            swap;
  logic            err_nxt;
  logic            at_last;

  assign at_last = (widx == WW'(F-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // A frame closes on in_last or on the final slot; only both together is a good frame.
  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    in_ready  = 1'b0;
    hs        = 1'b0;
    swap      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        hs       = in_valid;
        if (in_valid) begin
          if (at_last || in_last) begin
            widx_nxt = '0;
            if (at_last && in_last) state_nxt = FULL;
            else                    err_nxt   = 1'b1;
          end else begin
            widx_nxt = widx + 1'b1;
          end
        end
      end
      FULL: begin
        swap = !seed_valid || seed_ack;
        if (swap) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < F; i++) shadow[i] <= '0;
    end else if (hs) begin
      for (int i = 0; i < F; i++)
        if (widx == WW'(i)) shadow[i] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx        <= '0;
      dcnt        <= '0;
      frame_err   <= 1'b0;
      seed_valid  <= 1'b0;
      modulus_out <= '0;
      const_flat  <= '0;
      base_flat   <= '0;
      depth_out   <= '0;
    end else begin
      widx      <= widx_nxt;
      frame_err <= err_nxt;
      if (swap) begin
        modulus_out <= shadow[0];
        for (int k = 0; k < NCONST; k++) const_flat[k*DW +: DW] <= shadow[1+k];
        for (int k = 0; k < NBASE; k++)  base_flat[k*DW +: DW]  <= shadow[1+NCONST+k];
        depth_out  <= dcnt;
        dcnt       <= (dcnt == DCW'(DEPTH-1)) ? '0 : dcnt + 1'b1;
        seed_valid <= 1'b1;
      end else if (seed_ack) begin
        seed_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tf_seed_loader.sv
// tb/tb_tf_seed_loader.sv - Self-checking bench for tf_seed_loader.
// Frame table, hand sequences and random traffic against a frame-level reference model.
module tb_tf_seed_loader;
  localparam int DW = 64, NBASE = 15, NCONST = 14, DEPTH = 3;
  localparam int F = 1 + NCONST + NBASE;

  logic clk, rst, in_valid, in_last, in_ready, seed_valid, seed_ack, frame_err;
  logic [DW-1:0] in_data, modulus_out;
  logic [NBASE*DW-1:0] base_flat;
  logic [NCONST*DW-1:0] const_flat;
  logic [1:0] depth_out;

  tf_seed_loader #(.DW(DW), .NBASE(NBASE), .NCONST(NCONST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .seed_valid(seed_valid), .seed_ack(seed_ack),
    .base_flat(base_flat), .const_flat(const_flat), .modulus_out(modulus_out),
    .depth_out(depth_out), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference model: words of the frame in progress, one completed frame awaiting
  // the active bank, and the set currently presented.
  logic [63:0] m_cur [$];
  logic [63:0] m_pend_set [F];
  logic [63:0] m_act [F];
  bit m_pend, m_valid, m_err;
  int m_depth_out, m_dcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] base_lane(input int k);
    return base_flat[k*DW +: DW];
  endfunction

  function automatic logic [63:0] const_lane(input int k);
    return const_flat[k*DW +: DW];
  endfunction

  task automatic model_reset();
    m_cur.delete();
    for (int i = 0; i < F; i++) begin m_act[i] = '0; m_pend_set[i] = '0; end
    m_pend = 0; m_valid = 0; m_err = 0; m_depth_out = 0; m_dcnt = 0;
  endtask

  task automatic model_edge(input bit v, input logic [63:0] d, input bit l, input bit a);
    bit swapped = 0;
    bit err_n = 0;
    if (m_pend) begin
      if (!m_valid || a) begin
        swapped = 1;
        m_act = m_pend_set;
        m_depth_out = m_dcnt;
        m_dcnt = (m_dcnt + 1) % DEPTH;
        m_pend = 0;
      end
    end else if (v) begin
      m_cur.push_back(d);
      if (l || m_cur.size() == F) begin
        if (l && m_cur.size() == F) begin
          for (int i = 0; i < F; i++) m_pend_set[i] = m_cur[i];
          m_pend = 1;
        end else begin
          err_n = 1;
        end
        m_cur.delete();
      end
    end
    if (swapped) m_valid = 1;
    else if (a)  m_valid = 0;
    m_err = err_n;
  endtask

  task automatic model_check(input string tag);
    int bad;
    check({tag, " in_ready"}, in_ready, !m_pend);
    check({tag, " seed_valid"}, seed_valid, m_valid);
    check({tag, " frame_err"}, frame_err, m_err);
    check({tag, " depth_out"}, depth_out, m_depth_out);
    check({tag, " modulus_out"}, modulus_out, m_act[0]);
    bad = -1;
    for (int k = NBASE - 1; k >= 0; k--) if (base_lane(k) !== m_act[1+NCONST+k]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s base lane %0d: got %h expected %h", tag, bad, base_lane(bad), m_act[1+NCONST+bad]);
    end
    bad = -1;
    for (int k = NCONST - 1; k >= 0; k--) if (const_lane(k) !== m_act[1+k]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s const lane %0d: got %h expected %h", tag, bad, const_lane(bad), m_act[1+bad]);
    end
  endtask

  task automatic step(input bit v, input logic [63:0] d, input bit l, input bit a);
    in_valid = v; in_data = d; in_last = l; seed_ack = a;
    model_edge(v, d, l, a);
    @(posedge clk); #1;
    model_check("cyc");
  endtask

  task automatic send_frame(input logic [63:0] base, input int nwords, input int last_at);
    for (int i = 0; i < nwords; i++) step(1, base + 64'(i), i == last_at, 0);
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = '0; in_last = 0; seed_ack = 0;
    rst = 1;
    model_reset();
    #1;
    check("rst seed_valid", seed_valid, 0);
    check("rst modulus_out", modulus_out, 0);
    check("rst base_flat zero", base_flat == '0, 1);
    check("rst const_flat zero", const_flat == '0, 1);
    check("rst depth_out", depth_out, 0);
    check("rst frame_err", frame_err, 0);
    check("rst in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    model_check("post-rst");
  endtask

  typedef struct {
    logic [63:0] base;
    int nwords;
    int last_at;
    bit exp_err;
    bit exp_load;
    int exp_depth;
  } vec_t;

  vec_t vt [6];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{64'h100, 30, 29, 0, 1, 0};
    vt[1] = '{64'h1A0, 11, 10, 1, 0, 0};
    vt[2] = '{64'h200, 30, 29, 0, 1, 1};
    vt[3] = '{64'h2A0, 30, -1, 1, 0, 0};
    vt[4] = '{64'h300, 30, 29, 0, 1, 2};
    vt[5] = '{64'h400, 30, 29, 0, 1, 0};

    rst = 0; in_valid = 0; in_data = '0; in_last = 0; seed_ack = 0;
    #2;
    do_reset();

    for (int n = 0; n < 6; n++) begin
      send_frame(vt[n].base, vt[n].nwords, vt[n].last_at);
      check("vec frame_err", frame_err, vt[n].exp_err);
      check("vec in_ready after last", in_ready, !vt[n].exp_load);
      check("vec seed_valid early", seed_valid, 0);
      step(0, '0, 0, 0);
      check("vec seed_valid", seed_valid, vt[n].exp_load);
      check("vec frame_err clear", frame_err, 0);
      if (vt[n].exp_load) begin
        check("vec modulus", modulus_out, vt[n].base);
        check("vec const0", const_lane(0), vt[n].base + 64'd1);
        check("vec base14", base_lane(14), vt[n].base + 64'd29);
        check("vec depth", depth_out, vt[n].exp_depth);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
        check("vec hold seed_valid", seed_valid, 1);
        check("vec hold modulus", modulus_out, vt[n].base);
        step(0, '0, 0, 1);
        check("vec acked", seed_valid, 0);
      end else begin
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
        check("vec no load", seed_valid, 0);
      end
    end

    // Back-pressure: second frame waits in shadow until the first is acknowledged.
    do_reset();
    send_frame(64'h500, 30, 29);
    step(0, '0, 0, 0);
    check("bp first valid", seed_valid, 1);
    send_frame(64'h600, 30, 29);
    check("bp in_ready low", in_ready, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0);
    check("bp still first", modulus_out, 64'h500);
    check("bp stall in_ready", in_ready, 0);
    check("bp seed_valid held", seed_valid, 1);
    step(0, '0, 0, 1);
    check("bp swap seed_valid", seed_valid, 1);
    check("bp swap base0", base_lane(0), 64'h60F);
    check("bp swap modulus", modulus_out, 64'h600);
    check("bp swap depth", depth_out, 1);
    check("bp in_ready back", in_ready, 1);

    // Reset mid-frame while a seed is active.
    send_frame(64'h700, 20, -1);
    in_valid = 1; in_data = 64'h714;
    do_reset();
    send_frame(64'h800, 30, 29);
    step(0, '0, 0, 0);
    check("rst-reload valid", seed_valid, 1);
    check("rst-reload depth", depth_out, 0);
    check("rst-reload modulus", modulus_out, 64'h800);
    check("rst-reload base14", base_lane(14), 64'h81D);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit v, l, a;
      v = $urandom_range(0, 3) != 0;
      l = (m_cur.size() == F - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 59) == 0);
      a = $urandom_range(0, 2) == 0;
      step(v, {$urandom, $urandom}, l, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
